// File: rtl/stream_permute_n.sv
// stream_permute_n
//
// Joins N parallel token streams and re-emits them with the channels permuted.
// A "firing" consumes one token from every input channel at once (all-or-nothing)
// and loads an N-entry output register, where output entry k takes the token of
// input channel src(k). Each output channel then drains independently under its
// own backpressure. A simultaneous end-of-stream on every channel produces one
// EOS token per output and parks the block in DONE. An EOS on some channels
// but not others is an error: nothing is consumed and the block parks in ERR
// with a sticky err flag. Only reset leaves DONE or ERR.
//
// Parameters:
//   N    channel count (2..16)
//   W    data width per channel token
//   PERM N 4-bit fields, field k = source input index for output k (default identity)
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   cfg_we     map write enable          (only with STREAM_PERMUTE_PROG_EN)
//   cfg_sel    map entry to write        (only with STREAM_PERMUTE_PROG_EN)
//   cfg_src    new source index          (only with STREAM_PERMUTE_PROG_EN)
//   a_d        input data, channel i in bits [i*W+W-1:i*W]
//   a_e        input end-of-stream flag per channel
//   a_v        input valid per channel
//   a_b        input backpressure, 0 means the token is consumed this cycle
//   b_d        output data, driven from the output register
//   b_e        output end-of-stream flag
//   b_v        output valid (the per-channel pending bits)
//   b_b        output backpressure, token k leaves when b_v[k]=1 and b_b[k]=0
//   statecase  high exactly in a firing cycle
//   err        sticky mismatched-EOS flag
//
// Optional feature macro: STREAM_PERMUTE_PROG_EN
//   When defined, the permutation map is a register reloaded from PERM on reset
//   and written through the cfg_* ports. When undefined, the map is the
//   constant PERM and the cfg_* ports do not exist.

module stream_permute_n #(
    parameter int N = 8,
    parameter int W = 16,
    parameter logic [N*4-1:0] PERM = (N*4)'(64'hFEDC_BA98_7654_3210)
) (
    input  logic           clock,
    input  logic           reset,
`ifdef STREAM_PERMUTE_PROG_EN
    input  logic           cfg_we,
    input  logic [3:0]     cfg_sel,
    input  logic [3:0]     cfg_src,
`endif
    input  logic [N*W-1:0] a_d,
    input  logic [N-1:0]   a_e,
    input  logic [N-1:0]   a_v,
    output logic [N-1:0]   a_b,
    output logic [N*W-1:0] b_d,
    output logic [N-1:0]   b_e,
    output logic [N-1:0]   b_v,
    input  logic [N-1:0]   b_b,
    output logic           statecase,
    output logic           err
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     pending;
    logic [N-1:0]     eos_q;
    logic [N*W-1:0]   data_q;
    logic             err_q;
    logic [3:0]       map [N];
    logic [N*W-1:0]   perm_d;
    logic [N-1:0]     deliver;
    logic             reg_free;
    logic             all_v;
    logic             all_e0;
    logic             all_e1;
    logic             fire_data;
    logic             fire_eos;
    logic             fire;
    logic             mismatch;

`ifdef STREAM_PERMUTE_PROG_EN
    // Programmable map. A write lands on the clock edge, so a firing in the
    // same cycle still routes through the old entry. Out-of-range selectors or
    // sources are dropped so the map can never point outside the channel set.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                map[k] <= PERM[k*4 +: 4];
            end
        end else if (cfg_we && (int'(cfg_sel) < N) && (int'(cfg_src) < N)) begin
            for (int k = 0; k < N; k++) begin
                if (int'(cfg_sel) == k) begin
                    map[k] <= cfg_src;
                end
            end
        end
    end
`else
    // Fixed map taken straight from the parameter.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            map[k] = PERM[k*4 +: 4];
        end
    end
`endif

    // Route input tokens to output slots. A map entry that names a channel
    // beyond N (only possible through a bad PERM) yields zero data.
    always_comb begin
        perm_d = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(map[k]) < N) begin
                perm_d[k*W +: W] = a_d[int'(map[k])*W +: W];
            end
        end
    end

    // Firing decision. The register counts as free when every still-pending
    // slot is leaving this cycle, which gives one firing per cycle when the
    // outputs never stall. Firing is suppressed during reset so no token is
    // acknowledged and then thrown away.
    always_comb begin
        deliver   = pending & ~b_b;
        reg_free  = (deliver == pending);
        all_v     = &a_v;
        all_e0    = ~|a_e;
        all_e1    = &a_e;
        fire_data = !reset && (state == RUN) && all_v && all_e0 && reg_free;
        fire_eos  = !reset && (state == RUN) && all_v && all_e1 && reg_free;
        fire      = fire_data || fire_eos;
        mismatch  = !reset && (state == RUN) && all_v && !all_e0 && !all_e1;
    end

    assign a_b       = fire ? '0 : '1;
    assign statecase = fire;
    assign b_v       = pending;
    assign b_d       = data_q;
    assign b_e       = eos_q;
    assign err       = err_q;

    // State machine and output register. Pending bits clear one channel at a
    // time as each output delivers; a firing reloads every slot at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            pending <= '0;
            data_q  <= '0;
            eos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (fire) begin
                pending <= '1;
            end else begin
                pending <= pending & ~deliver;
            end

            if (fire_data) begin
                data_q <= perm_d;
                eos_q  <= '0;
            end else if (fire_eos) begin
                data_q <= '0;
                eos_q  <= '1;
            end

            case (state)
                RUN: begin
                    if (fire_eos) begin
                        state <= DONE;
                    end else if (mismatch) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_permute_n.sv
// tb_stream_permute_n
//
// Directed bench for stream_permute_n with N=8, W=16. Two instances share all
// inputs: one with the identity map, one with the reversed map (src(k)=7-k).
// Inputs change on the falling edge; combinational outputs (a_b, statecase)
// are checked shortly after that, registered outputs 1 ns after the rising
// edge. Programming scenarios run only when STREAM_PERMUTE_PROG_EN is defined.

module tb_stream_permute_n;

    localparam int N = 8;
    localparam int W = 16;

    logic           clock;
    logic           reset;
    logic           cfg_we;
    logic [3:0]     cfg_sel;
    logic [3:0]     cfg_src;
    logic [N*W-1:0] a_d;
    logic [N-1:0]   a_e;
    logic [N-1:0]   a_v;
    logic [N-1:0]   b_b;

    logic [N-1:0]   a_b;
    logic [N*W-1:0] b_d;
    logic [N-1:0]   b_e;
    logic [N-1:0]   b_v;
    logic           statecase;
    logic           err;

    logic [N-1:0]   r_a_b;
    logic [N*W-1:0] r_b_d;
    logic [N-1:0]   r_b_e;
    logic [N-1:0]   r_b_v;
    logic           r_statecase;
    logic           r_err;

    int errors;
    int checks;

    // Identity-map instance.
    stream_permute_n #(.N(N), .W(W)) dut (
        .clock(clock),
        .reset(reset),
`ifdef STREAM_PERMUTE_PROG_EN
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_src(cfg_src),
`endif
        .a_d(a_d),
        .a_e(a_e),
        .a_v(a_v),
        .a_b(a_b),
        .b_d(b_d),
        .b_e(b_e),
        .b_v(b_v),
        .b_b(b_b),
        .statecase(statecase),
        .err(err)
    );

    // Reversed-map instance: field k holds 7-k.
    stream_permute_n #(.N(N), .W(W), .PERM(32'h0123_4567)) dut_rev (
        .clock(clock),
        .reset(reset),
`ifdef STREAM_PERMUTE_PROG_EN
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_src(cfg_src),
`endif
        .a_d(a_d),
        .a_e(a_e),
        .a_v(a_v),
        .a_b(r_a_b),
        .b_d(r_b_d),
        .b_e(r_b_e),
        .b_v(r_b_v),
        .b_b(b_b),
        .statecase(r_statecase),
        .err(r_err)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [W-1:0] ch(input logic [N*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // Fill a_d with base+i on channel i.
    task automatic set_data(input int base);
        for (int i = 0; i < N; i++) begin
            a_d[i*W +: W] = W'(base + i);
        end
    endtask

    task automatic drive_edge();
        @(negedge clock);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        drive_edge();
        reset   = 1'b1;
        a_v     = '0;
        a_e     = '0;
        b_b     = '0;
        cfg_we  = 1'b0;
        cfg_sel = '0;
        cfg_src = '0;
        set_data(0);
        tick();
        drive_edge();
        reset = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (b_v !== 8'h00) begin errors++; $display("[TB] FAIL reset_b_v: got %h expected 00", b_v); end
        checks++;
        if (b_e !== 8'h00) begin errors++; $display("[TB] FAIL reset_b_e: got %h expected 00", b_e); end
        checks++;
        if (b_d !== '0) begin errors++; $display("[TB] FAIL reset_b_d: got %h expected 0", b_d); end
        checks++;
        if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL reset_a_b: got %h expected ff", a_b); end
        checks++;
        if (statecase !== 1'b0) begin errors++; $display("[TB] FAIL reset_statecase: got %b expected 0", statecase); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    endtask

    // Single data firing through both maps.
    task automatic test_data_fire();
        drive_edge();
        set_data(16'h0100);
        a_v = 8'hFF;
        a_e = 8'h00;
        b_b = 8'h00;
        #1;
        checks++;
        if (statecase !== 1'b1) begin errors++; $display("[TB] FAIL fire_statecase: got %b expected 1", statecase); end
        checks++;
        if (a_b !== 8'h00) begin errors++; $display("[TB] FAIL fire_a_b: got %h expected 00", a_b); end
        tick();
        checks++;
        if (b_v !== 8'hFF) begin errors++; $display("[TB] FAIL fire_b_v: got %h expected ff", b_v); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ch(b_d, k) !== W'(16'h0100 + k)) begin
                errors++;
                $display("[TB] FAIL fire_id_ch%0d: got %h expected %h", k, ch(b_d, k), W'(16'h0100 + k));
            end
        end
        checks++;
        if (ch(r_b_d, 0) !== 16'h0107) begin errors++; $display("[TB] FAIL fire_rev_ch0: got %h expected 0107", ch(r_b_d, 0)); end
        checks++;
        if (ch(r_b_d, 7) !== 16'h0100) begin errors++; $display("[TB] FAIL fire_rev_ch7: got %h expected 0100", ch(r_b_d, 7)); end
        checks++;
        if (b_e !== 8'h00) begin errors++; $display("[TB] FAIL fire_b_e: got %h expected 00", b_e); end
        drive_edge();
        a_v = 8'h00;
        tick();
        checks++;
        if (b_v !== 8'h00) begin errors++; $display("[TB] FAIL drain_b_v: got %h expected 00", b_v); end
    endtask

    // Consecutive firings with no output stall.
    task automatic test_back_to_back();
        drive_edge();
        set_data(16'h0200);
        a_v = 8'hFF;
        tick();
        drive_edge();
        set_data(16'h0300);
        #1;
        checks++;
        if (statecase !== 1'b1) begin errors++; $display("[TB] FAIL b2b_statecase: got %b expected 1", statecase); end
        tick();
        checks++;
        if (ch(b_d, 4) !== 16'h0304) begin errors++; $display("[TB] FAIL b2b_ch4: got %h expected 0304", ch(b_d, 4)); end
        checks++;
        if (b_v !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_b_v: got %h expected ff", b_v); end
        drive_edge();
        a_v = 8'h00;
        tick();
    endtask

    // One stalled output blocks the next firing but not the other channels.
    task automatic test_stall();
        drive_edge();
        set_data(16'h0400);
        a_v = 8'hFF;
        b_b = 8'h08;
        #1;
        checks++;
        if (statecase !== 1'b1) begin errors++; $display("[TB] FAIL stall_first_fire: got %b expected 1", statecase); end
        tick();
        for (int c = 0; c < 5; c++) begin
            drive_edge();
            #1;
            checks++;
            if (statecase !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_fire_c%0d: got %b expected 0", c, statecase); end
            checks++;
            if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL stall_a_b_c%0d: got %h expected ff", c, a_b); end
            tick();
            checks++;
            if (b_v !== 8'h08) begin errors++; $display("[TB] FAIL stall_b_v_c%0d: got %h expected 08", c, b_v); end
        end
        checks++;
        if (ch(b_d, 3) !== 16'h0403) begin errors++; $display("[TB] FAIL stall_hold_ch3: got %h expected 0403", ch(b_d, 3)); end
        drive_edge();
        set_data(16'h0500);
        b_b = 8'h00;
        #1;
        checks++;
        if (statecase !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_fire: got %b expected 1", statecase); end
        tick();
        checks++;
        if (ch(b_d, 3) !== 16'h0503) begin errors++; $display("[TB] FAIL stall_new_ch3: got %h expected 0503", ch(b_d, 3)); end
        drive_edge();
        a_v = 8'h00;
        tick();
    endtask

    // Reset with tokens still pending discards them.
    task automatic test_reset_mid();
        drive_edge();
        set_data(16'h0A00);
        a_v = 8'hFF;
        b_b = 8'hFF;
        tick();
        checks++;
        if (b_v !== 8'hFF) begin errors++; $display("[TB] FAIL midrst_loaded: got %h expected ff", b_v); end
        apply_reset();
        checks++;
        if (b_v !== 8'h00) begin errors++; $display("[TB] FAIL midrst_b_v: got %h expected 00", b_v); end
        checks++;
        if (b_d !== '0) begin errors++; $display("[TB] FAIL midrst_b_d: got %h expected 0", b_d); end
    endtask

`ifdef STREAM_PERMUTE_PROG_EN
    // Map writes take effect from the following firing; bad writes are dropped.
    task automatic test_prog();
        drive_edge();
        set_data(16'h0600);
        a_v     = 8'hFF;
        b_b     = 8'h00;
        cfg_we  = 1'b1;
        cfg_sel = 4'd0;
        cfg_src = 4'd5;
        tick();
        checks++;
        if (ch(b_d, 0) !== 16'h0600) begin errors++; $display("[TB] FAIL prog_old_map: got %h expected 0600", ch(b_d, 0)); end
        drive_edge();
        set_data(16'h0700);
        cfg_sel = 4'd0;
        cfg_src = 4'd9;
        tick();
        checks++;
        if (ch(b_d, 0) !== 16'h0705) begin errors++; $display("[TB] FAIL prog_new_map: got %h expected 0705", ch(b_d, 0)); end
        drive_edge();
        set_data(16'h0800);
        cfg_sel = 4'd9;
        cfg_src = 4'd2;
        tick();
        checks++;
        if (ch(b_d, 0) !== 16'h0805) begin errors++; $display("[TB] FAIL prog_bad_src: got %h expected 0805", ch(b_d, 0)); end
        drive_edge();
        cfg_we = 1'b0;
        set_data(16'h0900);
        tick();
        checks++;
        if (ch(b_d, 0) !== 16'h0905) begin errors++; $display("[TB] FAIL prog_bad_sel: got %h expected 0905", ch(b_d, 0)); end
        apply_reset();
        drive_edge();
        set_data(16'h0B00);
        a_v = 8'hFF;
        tick();
        checks++;
        if (ch(b_d, 0) !== 16'h0B00) begin errors++; $display("[TB] FAIL prog_reset_map: got %h expected 0b00", ch(b_d, 0)); end
        drive_edge();
        a_v = 8'h00;
        tick();
    endtask
`endif

    // All-channel EOS: one EOS token per output, then DONE refuses input.
    task automatic test_eos();
        drive_edge();
        set_data(16'h0C00);
        a_v = 8'hFF;
        a_e = 8'hFF;
        b_b = 8'h00;
        #1;
        checks++;
        if (a_b !== 8'h00) begin errors++; $display("[TB] FAIL eos_a_b: got %h expected 00", a_b); end
        checks++;
        if (statecase !== 1'b1) begin errors++; $display("[TB] FAIL eos_statecase: got %b expected 1", statecase); end
        tick();
        checks++;
        if (b_e !== 8'hFF) begin errors++; $display("[TB] FAIL eos_b_e: got %h expected ff", b_e); end
        checks++;
        if (b_v !== 8'hFF) begin errors++; $display("[TB] FAIL eos_b_v: got %h expected ff", b_v); end
        checks++;
        if (b_d !== '0) begin errors++; $display("[TB] FAIL eos_b_d: got %h expected 0", b_d); end
        drive_edge();
        a_e = 8'h00;
        #1;
        checks++;
        if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL done_a_b: got %h expected ff", a_b); end
        checks++;
        if (statecase !== 1'b0) begin errors++; $display("[TB] FAIL done_statecase: got %b expected 0", statecase); end
        tick();
        checks++;
        if (b_v !== 8'h00) begin errors++; $display("[TB] FAIL done_drain: got %h expected 00", b_v); end
        drive_edge();
        #1;
        checks++;
        if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL done_stays: got %h expected ff", a_b); end
        apply_reset();
    endtask

    // Mismatched EOS sets the sticky error and blocks input until reset.
    task automatic test_err();
        drive_edge();
        set_data(16'h0D00);
        a_v = 8'hFF;
        a_e = 8'h01;
        #1;
        checks++;
        if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL err_a_b: got %h expected ff", a_b); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b expected 1", err); end
        checks++;
        if (b_v !== 8'h00) begin errors++; $display("[TB] FAIL err_b_v: got %h expected 00", b_v); end
        drive_edge();
        a_e = 8'h00;
        #1;
        checks++;
        if (a_b !== 8'hFF) begin errors++; $display("[TB] FAIL err_blocked: got %h expected ff", a_b); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
        apply_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", err); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b1;
        cfg_we  = 1'b0;
        cfg_sel = '0;
        cfg_src = '0;
        a_d     = '0;
        a_e     = '0;
        a_v     = '0;
        b_b     = '0;
        $display("[TB] starting stream_permute_n bench");
        test_reset();
        test_data_fire();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef STREAM_PERMUTE_PROG_EN
        test_prog();
`endif
        test_eos();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
